// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sends a fixed sync pattern and then a parallel payload, MSB first, on x.
// Define SEQ_TX_PARITY_EN to append one even-parity bit after the payload.
module seq_pattern_tx #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1011,
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              x,
    output logic              valid,
    output logic              done
);

    localparam int MAX_LEN = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // A one-bit payload makes the first data bit also the last bit of the frame.
    localparam bit DATA_LAST_ON_ENTRY = !PAR_EN && (DATA_W == 1);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;
`endif

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [SYNC_W-1:0] sync_reg;
`ifdef SEQ_TX_PARITY_EN
    logic              par_reg;
`endif

    // Outputs are registered and always hold the bit that belongs to the current cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            sync_reg  <= '0;
`ifdef SEQ_TX_PARITY_EN
            par_reg   <= 1'b0;
`endif
            x         <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else if (start && ready) begin
            // Accepted from IDLE or from the last-bit cycle of the previous frame.
            state_reg <= ST_SYNC;
            cnt_reg   <= CNT_W'(SYNC_W - 1);
            shift_reg <= data_in;
            sync_reg  <= SYNC << 1;
`ifdef SEQ_TX_PARITY_EN
            par_reg   <= ^data_in;
`endif
            x         <= SYNC[SYNC_W-1];
            valid     <= 1'b1;
            done      <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state_reg)
                ST_SYNC: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DATA;
                        cnt_reg   <= CNT_W'(DATA_W - 1);
                        x         <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                        done      <= DATA_LAST_ON_ENTRY;
                        ready     <= DATA_LAST_ON_ENTRY;
                    end else begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        x         <= sync_reg[SYNC_W-1];
                        sync_reg  <= sync_reg << 1;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == '0) begin
`ifdef SEQ_TX_PARITY_EN
                        state_reg <= ST_PAR;
                        x         <= par_reg;
                        done      <= 1'b1;
                        ready     <= 1'b1;
`else
                        state_reg <= ST_IDLE;
                        x         <= 1'b0;
                        valid     <= 1'b0;
                        done      <= 1'b0;
                        ready     <= 1'b1;
`endif
                    end else begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        x         <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                        done      <= !PAR_EN && (cnt_reg == CNT_W'(1));
                        ready     <= !PAR_EN && (cnt_reg == CNT_W'(1));
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PAR: begin
                    state_reg <= ST_IDLE;
                    x         <= 1'b0;
                    valid     <= 1'b0;
                    done      <= 1'b0;
                    ready     <= 1'b1;
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                    x         <= 1'b0;
                    valid     <= 1'b0;
                    done      <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random frames checked cycle by cycle against a bit-queue model.
module tb_seq_pattern_tx;

    localparam int                SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC   = 4'b1011;
    localparam int                DATA_W = 8;
`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = SYNC_W + DATA_W + 1;
`else
    localparam int FRAME_LEN = SYNC_W + DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              x;
    logic              valid;
    logic              done;

    int          checks = 0;
    int          errors = 0;
    int          valid_cnt;
    int          done_cnt;
    logic [31:0] seen;
    logic        q[$];   // bits still to be sent; front is the bit on x now

    seq_pattern_tx #(.SYNC_W(SYNC_W), .SYNC(SYNC), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .ready(ready), .x(x), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d);
        logic [SYNC_W-1:0] s;
        s = SYNC;
        for (int i = SYNC_W - 1; i >= 0; i--) q.push_back(s[i]);
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SEQ_TX_PARITY_EN
        q.push_back(^d);
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic ex, ev, ed, er;
        if (q.size() > 0) begin
            ex = q[0]; ev = 1'b1; ed = (q.size() == 1); er = ed;
        end else begin
            ex = 1'b0; ev = 1'b0; ed = 1'b0; er = 1'b1;
        end
        chk({tag, ".x"},     32'(x),     32'(ex));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".done"},  32'(done),  32'(ed));
        chk({tag, ".ready"}, 32'(ready), 32'(er));
    endtask

    // Drive one cycle's inputs, advance the model over the edge, then check at the falling edge.
    task automatic cycle(input string tag, input logic s, input logic [DATA_W-1:0] d);
        logic acc;
        start   = s;
        data_in = d;
        @(posedge clk);
        acc = s && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) push_frame(d);
        @(negedge clk);
        if (valid === 1'b1) begin
            valid_cnt++;
            seen = {seen[30:0], x};
        end
        if (done === 1'b1) done_cnt++;
        check_outputs(tag);
        $display("%s start=%0b data_in=%02h x=%0b valid=%0b done=%0b ready=%0b",
                 tag, s, d, x, valid, done, ready);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; data_in = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_outputs("in_reset");
        reset = 1'b0;
        q.delete();
        check_outputs("post_reset");

        // Idle without start
        repeat (5) cycle("idle", 1'b0, DATA_W'($urandom));

        // Single frame A5
        seen = '0; valid_cnt = 0; done_cnt = 0;
        cycle("a5", 1'b1, 8'hA5);
        repeat (FRAME_LEN) cycle("a5", 1'b0, 8'h00);
`ifdef SEQ_TX_PARITY_EN
        chk("a5_bits", seen, 32'h174A);
`else
        chk("a5_bits", seen, 32'h0BA5);
`endif
        chk("a5_len", 32'(valid_cnt), 32'(FRAME_LEN));
        chk("a5_done", 32'(done_cnt), 32'd1);

        // Start held high while busy: ignored until the last-bit cycle
        cycle("busy", 1'b1, 8'h0F);
        repeat (FRAME_LEN) cycle("busy", 1'b1, 8'hFF);
        repeat (FRAME_LEN) cycle("busy", 1'b0, 8'h00);

        // Back-to-back frames 3C then C3
        seen = '0; valid_cnt = 0; done_cnt = 0;
        cycle("b2b", 1'b1, 8'h3C);
        repeat (FRAME_LEN - 1) cycle("b2b", 1'b0, 8'h00);
        cycle("b2b", 1'b1, 8'hC3);
        repeat (FRAME_LEN) cycle("b2b", 1'b0, 8'h00);
        chk("b2b_len", 32'(valid_cnt), 32'(2 * FRAME_LEN));
        chk("b2b_done", 32'(done_cnt), 32'd2);
`ifndef SEQ_TX_PARITY_EN
        chk("b2b_bits", seen[23:0], 32'h00B3CBC3);
`endif

        // Asynchronous reset during payload bit 3
        cycle("rst", 1'b1, 8'hA5);
        repeat (SYNC_W + 2) cycle("rst", 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1 q.delete();
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("rst_hold");
        reset = 1'b0;
        seen = '0; valid_cnt = 0; done_cnt = 0;
        cycle("rst", 1'b1, 8'h01);
        repeat (FRAME_LEN) cycle("rst", 1'b0, 8'h00);
`ifdef SEQ_TX_PARITY_EN
        chk("rst_bits", seen, 32'h1603);
`else
        chk("rst_bits", seen, 32'h0B01);
`endif
        chk("rst_done", 32'(done_cnt), 32'd1);

`ifdef SEQ_TX_PARITY_EN
        seen = '0;
        cycle("par07", 1'b1, 8'h07);
        repeat (FRAME_LEN) cycle("par07", 1'b0, 8'h00);
        chk("par07_bit", 32'(seen[0]), 32'd1);
`endif

        // Random traffic, including start while busy and in the last-bit cycle
        for (int i = 0; i < 400; i++)
            cycle("rand", ($urandom_range(0, 3) == 0), DATA_W'($urandom));
        repeat (FRAME_LEN + 1) cycle("drain", 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
